// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 load unit: access sizes, FSM state codes and
// the XLEN legality check.
package msrv32_pkg;

    localparam logic [1:0] LU_SIZE_BYTE   = 2'b00;
    localparam logic [1:0] LU_SIZE_HALF   = 2'b01;
    localparam logic [1:0] LU_SIZE_WORD   = 2'b10;
    localparam logic [1:0] LU_SIZE_DOUBLE = 2'b11;

    localparam logic [1:0] LU_IDLE = 2'b00;
    localparam logic [1:0] LU_WAIT = 2'b01;
    localparam logic [1:0] LU_ERR  = 2'b10;

    function automatic bit lu_xlen_ok(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/msrv32_lu_extract.sv
// Combinational lane select and sign/zero extension of AHB read data.
// Offsets below the access size are ignored, so every access is aligned down.
module msrv32_lu_extract
    import msrv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]              data,
    input  logic [1:0]                   size,
    input  logic                         zero_ext,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    output logic [XLEN-1:0]              result
);
    localparam int unsigned ADDR_LSB = $clog2(XLEN / 8);
    localparam int unsigned OFF_W    = ADDR_LSB + 3;

    logic [OFF_W-1:0] byte_sh;
    logic [OFF_W-1:0] half_sh;
    logic [OFF_W-1:0] word_sh;
    logic [XLEN-1:0]  byte_lane_all;
    logic [XLEN-1:0]  half_lane_all;
    logic [XLEN-1:0]  word_lane_all;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      lane_w;

    always_comb begin
        // Bit offsets; masking the low bits aligns half/word lanes down.
        byte_sh       = {offset, 3'b000};
        half_sh       = byte_sh & ~OFF_W'(15);
        word_sh       = byte_sh & ~OFF_W'(31);
        byte_lane_all = data >> byte_sh;
        half_lane_all = data >> half_sh;
        word_lane_all = data >> word_sh;
        lane_b        = byte_lane_all[7:0];
        lane_h        = half_lane_all[15:0];
        lane_w        = word_lane_all[31:0];
    end

    always_comb begin
        result = data;
        unique case (size)
            LU_SIZE_BYTE: result = zero_ext ? XLEN'(lane_b) : XLEN'($signed(lane_b));
            LU_SIZE_HALF: result = zero_ext ? XLEN'(lane_h) : XLEN'($signed(lane_h));
            LU_SIZE_WORD: result = zero_ext ? XLEN'(lane_w) : XLEN'($signed(lane_w));
            // Double, or word at XLEN=32: full bus width, extension flag ignored.
            LU_SIZE_DOUBLE: result = data;
            default: result = data;
        endcase
    end

endmodule

// File: rtl/msrv32_lu_ahb.sv
// Registered load unit: captures load attributes, follows one AHB-Lite read
// data phase, then lane-selects and extends HRDATA. LU_MISALIGN_TRAP_EN enables the misalignment trap.
module msrv32_lu_ahb
    import msrv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      load_req_in,
    input  logic [1:0]                load_size_in,
    input  logic                      load_unsigned_in,
    input  logic [$clog2(XLEN/8)-1:0] iadder_lsb_in,
    input  logic [4:0]                rd_addr_in,
    output logic                      hreq_out,
    input  logic [XLEN-1:0]           hrdata_in,
    input  logic                      hready_in,
    input  logic                      hresp_in,
    output logic                      lu_busy_out,
    output logic                      lu_valid_out,
    output logic [XLEN-1:0]           lu_output,
    output logic [4:0]                lu_rd_addr_out,
    output logic                      lu_err_out,
    output logic                      lu_misalign_out
);
    localparam int unsigned ADDR_LSB = $clog2(XLEN / 8);

    if (!lu_xlen_ok(XLEN)) begin : gen_bad_xlen
        $error("msrv32_lu_ahb: XLEN must be 32 or 64");
    end

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic [ADDR_LSB-1:0] off_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     out_q;
    logic [4:0]          rd_out_q;
    logic                valid_q;
    logic                err_q;
    logic                misaligned;
    logic                is_idle;
    logic                accept;
    logic                trap;
    logic                data_done;
    logic                err_done;
    logic [XLEN-1:0]     ext_data;

`ifdef LU_MISALIGN_TRAP_EN
    logic misalign_q;

    always_comb begin
        misaligned = 1'b0;
        unique case (load_size_in)
            LU_SIZE_BYTE:   misaligned = 1'b0;
            LU_SIZE_HALF:   misaligned = iadder_lsb_in[0];
            LU_SIZE_WORD:   misaligned = |iadder_lsb_in[1:0];
            LU_SIZE_DOUBLE: misaligned = (XLEN == 64) ? |iadder_lsb_in : |iadder_lsb_in[1:0];
            default:        misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) misalign_q <= 1'b0;
        else        misalign_q <= trap;
    end

    assign lu_misalign_out = misalign_q;
`else
    assign misaligned      = 1'b0;
    assign lu_misalign_out = 1'b0;
`endif

    assign is_idle   = (state_q == LU_IDLE);
    assign accept    = load_req_in && is_idle && !misaligned;
    assign trap      = load_req_in && is_idle && misaligned;
    assign data_done = (state_q == LU_WAIT) && hready_in && !hresp_in;
    // A one-cycle ERROR (HREADY high with HRESP) in the data phase also completes as an error.
    assign err_done  = ((state_q == LU_ERR) && hready_in) ||
                       ((state_q == LU_WAIT) && hready_in && hresp_in);

    always_comb begin
        state_d = state_q;
        case (state_q)
            LU_IDLE: if (accept) state_d = LU_WAIT;
            LU_WAIT: begin
                if (hready_in)     state_d = LU_IDLE;
                else if (hresp_in) state_d = LU_ERR;
            end
            LU_ERR:  if (hready_in) state_d = LU_IDLE;
            default: state_d = LU_IDLE;
        endcase
    end

    msrv32_lu_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .data     (hrdata_in),
        .size     (size_q),
        .zero_ext (unsigned_q),
        .offset   (off_q),
        .result   (ext_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= LU_IDLE;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            off_q      <= '0;
            rd_q       <= 5'd0;
            out_q      <= '0;
            rd_out_q   <= 5'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= data_done;
            err_q   <= err_done;
            if (accept) begin
                size_q     <= load_size_in;
                unsigned_q <= load_unsigned_in;
                off_q      <= iadder_lsb_in;
                rd_q       <= rd_addr_in;
            end
            if (data_done) out_q <= ext_data;
            if (data_done || err_done) rd_out_q <= rd_q;
            else if (trap)             rd_out_q <= rd_addr_in;
        end
    end

    assign hreq_out       = accept;
    assign lu_busy_out    = !is_idle;
    assign lu_valid_out   = valid_q;
    assign lu_err_out     = err_q;
    assign lu_output      = out_q;
    assign lu_rd_addr_out = rd_out_q;

endmodule

// File: tb/tb_msrv32_lu_ahb.sv
// Self-checking bench: XLEN=32 and XLEN=64 load units driven in lockstep,
// compared against an arithmetic reference model of the load rules.
module tb_msrv32_lu_ahb;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [1:0]  load_size;
    logic        load_uns;
    logic [2:0]  off;
    logic [4:0]  rd;
    logic [63:0] hrdata;
    logic        hready;
    logic        hresp;

    logic        hreq32, busy32, valid32, err32, mis32;
    logic [31:0] out32;
    logic [4:0]  rdo32;
    logic        hreq64, busy64, valid64, err64, mis64;
    logic [63:0] out64;
    logic [4:0]  rdo64;

    int tests  = 0;
    int failed = 0;

    logic [63:0] exp_out32 = '0;
    logic [63:0] exp_out64 = '0;
    logic [4:0]  exp_rd    = '0;

    always #5 clk = ~clk;

    msrv32_lu_ahb #(.XLEN(32)) dut32 (
        .clk_in           (clk),
        .rst_in           (rst),
        .load_req_in      (load_req),
        .load_size_in     (load_size),
        .load_unsigned_in (load_uns),
        .iadder_lsb_in    (off[1:0]),
        .rd_addr_in       (rd),
        .hreq_out         (hreq32),
        .hrdata_in        (hrdata[31:0]),
        .hready_in        (hready),
        .hresp_in         (hresp),
        .lu_busy_out      (busy32),
        .lu_valid_out     (valid32),
        .lu_output        (out32),
        .lu_rd_addr_out   (rdo32),
        .lu_err_out       (err32),
        .lu_misalign_out  (mis32)
    );

    msrv32_lu_ahb #(.XLEN(64)) dut64 (
        .clk_in           (clk),
        .rst_in           (rst),
        .load_req_in      (load_req),
        .load_size_in     (load_size),
        .load_unsigned_in (load_uns),
        .iadder_lsb_in    (off),
        .rd_addr_in       (rd),
        .hreq_out         (hreq64),
        .hrdata_in        (hrdata),
        .hready_in        (hready),
        .hresp_in         (hresp),
        .lu_busy_out      (busy64),
        .lu_valid_out     (valid64),
        .lu_output        (out64),
        .lu_rd_addr_out   (rdo64),
        .lu_err_out       (err64),
        .lu_misalign_out  (mis64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Access size in bytes; double at XLEN=32 is a word.
    function automatic int unsigned nbytes(input int unsigned xlen, input logic [1:0] sz);
        int unsigned n;
        n = 1 << sz;
        if (n > xlen / 8) n = xlen / 8;
        return n;
    endfunction

    function automatic logic [63:0] model(input int unsigned xlen, input logic [63:0] data,
                                          input logic [1:0] sz, input logic uns,
                                          input logic [2:0] o);
        int unsigned n, offs, base;
        logic [63:0] d, mask, val;
        n    = nbytes(xlen, sz);
        offs = int'(o) % (xlen / 8);
        base = offs - (offs % n);
        d    = (xlen == 32) ? {32'h0, data[31:0]} : data;
        mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        val  = (d >> (8 * base)) & mask;
        if (!uns && (8 * n < xlen) && val[8 * n - 1]) val = val | ~mask;
        if (xlen == 32) val = val & 64'h0000_0000_FFFF_FFFF;
        return val;
    endfunction

    function automatic bit mis_model(input int unsigned xlen, input logic [1:0] sz,
                                     input logic [2:0] o);
`ifdef LU_MISALIGN_TRAP_EN
        int unsigned n, offs;
        n    = nbytes(xlen, sz);
        offs = int'(o) % (xlen / 8);
        return (n > 1) && ((offs % n) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid32"}, valid32, 0);
        check({tag, "_valid64"}, valid64, 0);
        check({tag, "_err32"}, err32, 0);
        check({tag, "_err64"}, err64, 0);
    endtask

    task automatic do_load(input logic [1:0] sz, input logic uns, input logic [2:0] o,
                           input logic [4:0] rd_t, input logic [63:0] data,
                           input int waits, input bit err);
        bit m32, m64;
        int busy_n;
        m32 = mis_model(32, sz, o);
        m64 = mis_model(64, sz, o);
        @(negedge clk);
        load_req  = 1'b1;
        load_size = sz;
        load_uns  = uns;
        off       = o;
        rd        = rd_t;
        hrdata    = {$urandom, $urandom};
        #1;
        check("hreq32", hreq32, !m32);
        check("hreq64", hreq64, !m64);
        @(negedge clk);
        load_req = 1'b0;
        rd       = 5'($urandom);
        if (m32) begin
            exp_rd = rd_t;
            #1;
            check("mis_pulse32", mis32, 1);
            check("mis_pulse64", mis64, m64);
            check("mis_busy32", busy32, 0);
            check("mis_rd32", rdo32, exp_rd);
            check("mis_out32", out32, exp_out32);
            check("mis_out64", out64, exp_out64);
            @(negedge clk);
            #1;
            check("mis_drop32", mis32, 0);
            return;
        end
        busy_n = 0;
        for (int i = 0; i < waits; i++) begin
            hready = 1'b0;
            hresp  = 1'b0;
            hrdata = {$urandom, $urandom};
            #1;
            if (busy32 && busy64) busy_n++;
            check("wait_out32", out32, exp_out32);
            check("wait_valid64", valid64, 0);
            @(negedge clk);
        end
        if (err) begin
            hready = 1'b0;
            hresp  = 1'b1;
            #1;
            if (busy32 && busy64) busy_n++;
            @(negedge clk);
            hready = 1'b1;
            #1;
            if (busy32 && busy64) busy_n++;
            @(negedge clk);
            hresp = 1'b0;
            #1;
            check("err_pulse32", err32, 1);
            check("err_pulse64", err64, 1);
            check("err_novalid32", valid32, 0);
            check("err_novalid64", valid64, 0);
            check("err_out32", out32, exp_out32);
            check("err_out64", out64, exp_out64);
            check("err_busy_cycles", busy_n, waits + 2);
        end else begin
            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = data;
            #1;
            if (busy32 && busy64) busy_n++;
            @(negedge clk);
            hrdata = {$urandom, $urandom};
            exp_out32 = model(32, data, sz, uns, o);
            exp_out64 = model(64, data, sz, uns, o);
            exp_rd    = rd_t;
            #1;
            check("valid32", valid32, 1);
            check("valid64", valid64, 1);
            check("out32", out32, exp_out32);
            check("out64", out64, exp_out64);
            check("rd32", rdo32, exp_rd);
            check("rd64", rdo64, exp_rd);
            check("busy_after", busy32 | busy64, 0);
            check("busy_cycles", busy_n, waits + 1);
        end
        @(negedge clk);
        #1;
        check_idle_outputs("post");
    endtask

    initial begin
        rst       = 1'b1;
        load_req  = 1'b0;
        load_size = 2'b00;
        load_uns  = 1'b0;
        off       = 3'd0;
        rd        = 5'd0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out32", out32, 0);
        check("rst_out64", out64, 0);
        check("rst_rd32", rdo32, 0);
        check("rst_busy", busy32 | busy64, 0);
        check("rst_mis", mis32 | mis64, 0);
        check_idle_outputs("rst");
        rst = 1'b0;

        // lbu off=3, zero wait
        do_load(2'b00, 1'b1, 3'd3, 5'd7, 64'h0000_0000_80FF_1234, 0, 1'b0);
        check("lbu_const", out32, 64'h80);
        // lh off=2, three wait states
        do_load(2'b01, 1'b0, 3'd2, 5'd9, 64'h0000_0000_8001_0000, 3, 1'b0);
        check("lh_const", out32, 64'hFFFF_8001);
        // error response leaves data untouched
        do_load(2'b10, 1'b0, 3'd0, 5'd3, 64'h1111_2222_3333_4444, 1, 1'b1);
        check("err_const", out32, 64'hFFFF_8001);
        // ld / lw at XLEN=64
        do_load(2'b11, 1'b0, 3'd0, 5'd12, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
        check("ld_const", out64, 64'hDEAD_BEEF_0123_4567);
        do_load(2'b10, 1'b0, 3'd4, 5'd13, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
        check("lw_const", out64, 64'hFFFF_FFFF_DEAD_BEEF);
        // misaligned word
        do_load(2'b10, 1'b0, 3'd1, 5'd21, 64'h0000_0000_89AB_CDEF, 0, 1'b0);
`ifndef LU_MISALIGN_TRAP_EN
        check("lw_mis_const", out32, 64'h89AB_CDEF);
`endif

        // Reset while waiting for data aborts the transfer.
        @(negedge clk);
        load_req  = 1'b1;
        load_size = 2'b00;
        off       = 3'd1;
        rd        = 5'd30;
        @(negedge clk);
        load_req = 1'b0;
        hready   = 1'b0;
        #1;
        check("pre_rst_busy", busy32, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy32 | busy64, 0);
        check("arst_out32", out32, 0);
        check("arst_out64", out64, 0);
        check("arst_rd", rdo64, 0);
        @(negedge clk);
        rst    = 1'b0;
        hready = 1'b1;
        exp_out32 = '0;
        exp_out64 = '0;
        exp_rd    = '0;
        #1;
        check_idle_outputs("arst_rel");
        do_load(2'b00, 1'b0, 3'd6, 5'd5, 64'h00C3_0000_0000_0000, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            logic [1:0] sz;
            logic [2:0] o;
            sz = 2'($urandom);
            o  = 3'($urandom);
            // Keep both widths agreeing on misalignment for doubles.
            if (sz == 2'b11 && o[1:0] == 2'b00) o = 3'd0;
            do_load(sz, 1'($urandom), o, 5'($urandom), {$urandom, $urandom},
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
